// File: rtl/reg_file_pkg.sv
// Shared constants and the byte-enable merge used by both the write port and the read bypass.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    // Widest register the merge helper handles; callers size-cast in and out.
    localparam int MERGE_W    = 256;
    localparam int MERGE_BE_W = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] merge_be(
        input logic [MERGE_W-1:0]    old_val,
        input logic [MERGE_W-1:0]    new_val,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_val;
        for (int k = 0; k < MERGE_BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Register-file bus: read ports, byte-enabled write port and destination reservation.
interface reg_file_sb_if #(
    parameter int DATA_W = reg_file_pkg::DATA_W_DEF,
    parameter int ADDR_W = reg_file_pkg::ADDR_W_DEF,
    parameter int NUM_RD = 2
) ();

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ready;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [DATA_W/8-1:0]      wr_be;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     rsv_conflict;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_be, rsv_en, rsv_addr,
        input  rd_data, rd_ready, rsv_conflict
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_be, rsv_en, rsv_addr,
        output rd_data, rd_ready, rsv_conflict
    );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reservation, cleared by writeback.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_ready,
    output logic                     rsv_conflict
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] pending_next;
    logic             conflict_reg;
    logic             conflict_next;
    logic             rsv_ok;

    assign rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == '0);

    // Clear first, then set, so a same-cycle reserve by the next producer wins.
    always_comb begin
        pending_next = pending_reg;
        if (wr_en) begin
            pending_next[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            pending_next[rsv_addr] = 1'b1;
        end
        conflict_next = conflict_reg ||
                        (rsv_ok && pending_reg[rsv_addr] && !(wr_en && wr_addr == rsv_addr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg  <= '0;
            conflict_reg <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            conflict_reg <= conflict_next;
        end
    end

    assign rsv_conflict = conflict_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_ready
            logic [ADDR_W-1:0] addr;
            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
            assign rd_ready[gi] = (ZERO_REG && addr == '0) ||
                                  !pending_reg[addr] ||
                                  (wr_en && wr_addr == addr);
        end
    endgenerate

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with byte-enabled writes, same-cycle bypass and scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] wr_merged;
    logic              wr_ok;

    assign wr_ok     = bus.wr_en && !(ZERO_REG && bus.wr_addr == '0);
    assign wr_merged = DATA_W'(merge_be(MERGE_W'(mem_reg[bus.wr_addr]),
                                        MERGE_W'(bus.wr_data),
                                        MERGE_BE_W'(bus.wr_be)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_reg[bus.wr_addr] <= wr_merged;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] base;
            logic [DATA_W-1:0] bypassed;
            logic              hit;

            assign addr     = bus.rd_addr[gi*ADDR_W +: ADDR_W];
            assign base     = mem_reg[addr];
            assign hit      = bus.wr_en && (bus.wr_addr == addr);
            // Bypass merges the in-flight bytes over the stored value, exactly as the write will.
            assign bypassed = DATA_W'(merge_be(MERGE_W'(base),
                                               MERGE_W'(bus.wr_data),
                                               MERGE_BE_W'(bus.wr_be)));
            assign bus.rd_data[gi*DATA_W +: DATA_W] =
                (ZERO_REG && addr == '0) ? '0 : (hit ? bypassed : base);
        end
    endgenerate

    reg_file_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (bus.wr_en),
        .wr_addr      (bus.wr_addr),
        .rsv_en       (bus.rsv_en),
        .rsv_addr     (bus.rsv_addr),
        .rd_addr      (bus.rd_addr),
        .rd_ready     (bus.rd_ready),
        .rsv_conflict (bus.rsv_conflict)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed plus randomized checks of reg_file_sb against a behavioural register/pending model.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4)) bus_b ();

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    reg_file_sb #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b1)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    // Reference model for dut_a
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_conf;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_conf = 1'b0;
    endtask

    function automatic logic [31:0] exp_data(input int a);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = m_mem[a];
        if (bus_a.wr_en && int'(bus_a.wr_addr) == a)
            for (int k = 0; k < 4; k++)
                if (bus_a.wr_be[k]) v[8*k +: 8] = bus_a.wr_data[8*k +: 8];
        return v;
    endfunction

    function automatic logic exp_ready(input int a);
        if (a == 0) return 1'b1;
        return !m_pend[a] || (bus_a.wr_en && int'(bus_a.wr_addr) == a);
    endfunction

    task automatic check_a(input string tag);
        for (int p = 0; p < 2; p++) begin
            int a;
            a = int'(bus_a.rd_addr[p*5 +: 5]);
            chk($sformatf("%s data%0d r%0d", tag, p, a), bus_a.rd_data[p*32 +: 32], exp_data(a));
            chk($sformatf("%s ready%0d r%0d", tag, p, a), 32'(bus_a.rd_ready[p]), 32'(exp_ready(a)));
        end
        chk({tag, " conflict"}, 32'(bus_a.rsv_conflict), 32'(m_conf));
    endtask

    task automatic drive_a(input bit we, input int wa, input logic [31:0] wd, input logic [3:0] be,
                           input bit re, input int ra, input int r0, input int r1);
        bus_a.wr_en    = we;
        bus_a.wr_addr  = 5'(wa);
        bus_a.wr_data  = wd;
        bus_a.wr_be    = be;
        bus_a.rsv_en   = re;
        bus_a.rsv_addr = 5'(ra);
        bus_a.rd_addr  = {5'(r1), 5'(r0)};
    endtask

    task automatic drive_b(input bit we, input int wa, input logic [31:0] wd, input logic [3:0] be,
                           input bit re, input int ra, input int a0, input int a1, input int a2, input int a3);
        bus_b.wr_en    = we;
        bus_b.wr_addr  = 3'(wa);
        bus_b.wr_data  = wd;
        bus_b.wr_be    = be;
        bus_b.rsv_en   = re;
        bus_b.rsv_addr = 3'(ra);
        bus_b.rd_addr  = {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endtask

    // Advance one clock, applying the spec's update rules to the model with the current inputs.
    task automatic tick();
        int wa, ra;
        wa = int'(bus_a.wr_addr);
        ra = int'(bus_a.rsv_addr);
        @(posedge clk);
        if (bus_a.rsv_en && ra != 0 && m_pend[ra] && !(bus_a.wr_en && wa == ra)) m_conf = 1'b1;
        if (bus_a.wr_en && wa != 0) begin
            for (int k = 0; k < 4; k++)
                if (bus_a.wr_be[k]) m_mem[wa][8*k +: 8] = bus_a.wr_data[8*k +: 8];
            m_pend[wa] = 1'b0;
        end
        if (bus_a.rsv_en && ra != 0) m_pend[ra] = 1'b1;
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        #1;
        check_a(tag);
        tick();
    endtask

    initial begin
        model_reset();
        drive_a(0, 0, 0, 0, 0, 0, 1, 2);
        drive_b(0, 0, 0, 0, 0, 0, 0, 1, 2, 3);
        @(negedge clk);
        @(negedge clk);
        check_a("reset");
        chk("reset ready_b", 32'(bus_b.rd_ready), 32'hF);
        rst = 1'b0;

        // Write then partial byte write to r1
        drive_a(1, 1, 32'h0000_0064, 4'b1111, 0, 0, 1, 0); step("wr r1 full");
        drive_a(1, 1, 32'hFFFF_AB00, 4'b0010, 0, 0, 1, 0); step("wr r1 be2");
        drive_a(0, 0, 0, 0, 0, 0, 1, 0);
        #1 chk("r1 readback", bus_a.rd_data[31:0], 32'h0000_AB64);
        step("r1 idle");

        // Same-cycle bypass
        drive_a(1, 2, 32'h0000_01F4, 4'b1111, 0, 0, 2, 1);
        #1 chk("bypass r2 data", bus_a.rd_data[31:0], 32'h0000_01F4);
        chk("bypass r2 ready", 32'(bus_a.rd_ready[0]), 32'h1);
        step("bypass r2");

        // Reserve r5, hold off, then write it back
        drive_a(0, 0, 0, 0, 1, 5, 5, 2); step("rsv r5 c0");
        for (int c = 1; c <= 3; c++) begin
            drive_a(0, 0, 0, 0, 0, 0, 5, 2);
            #1 chk($sformatf("r5 pending c%0d", c), 32'(bus_a.rd_ready[0]), 32'h0);
            step("r5 wait");
        end
        drive_a(1, 5, 32'hCAFE_0005, 4'b1111, 0, 0, 5, 5);
        #1 chk("r5 wb ready", 32'(bus_a.rd_ready[0]), 32'h1);
        chk("r5 wb data", bus_a.rd_data[31:0], 32'hCAFE_0005);
        step("r5 wb");
        for (int c = 5; c <= 6; c++) begin
            drive_a(0, 0, 0, 0, 0, 0, 5, 1);
            #1 chk($sformatf("r5 ready c%0d", c), 32'(bus_a.rd_ready[0]), 32'h1);
            step("r5 after");
        end

        // Same-cycle write and reserve on r8: reserve wins, no conflict
        drive_a(0, 0, 0, 0, 1, 8, 8, 0); step("rsv r8");
        drive_a(1, 8, 32'h0808_0808, 4'b1111, 1, 8, 8, 0); step("wr+rsv r8");
        drive_a(0, 0, 0, 0, 0, 0, 8, 0);
        #1 chk("r8 still pending", 32'(bus_a.rd_ready[0]), 32'h0);
        chk("r8 no conflict", 32'(bus_a.rsv_conflict), 32'h0);
        step("r8 idle");
        drive_a(1, 8, 32'h1111_2222, 4'b1111, 0, 0, 8, 0); step("r8 wb");

        // Zero register on both configurations
        drive_a(1, 0, 32'hDEAD_BEEF, 4'b1111, 1, 0, 0, 0);
        drive_b(1, 0, 32'hDEAD_BEEF, 4'b1111, 1, 0, 0, 0, 0, 0);
        #1 chk("r0 data", bus_a.rd_data[31:0], 32'h0);
        for (int p = 0; p < 4; p++) chk($sformatf("b r0 data%0d", p), bus_b.rd_data[p*32 +: 32], 32'h0);
        chk("b r0 ready", 32'(bus_b.rd_ready), 32'hF);
        step("r0 wr+rsv");
        drive_b(1, 3, 32'h1234_5678, 4'b0101, 1, 6, 3, 6, 0, 3);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("r0 after ready", 32'(bus_a.rd_ready), 32'h3);
        chk("r0 no conflict", 32'(bus_a.rsv_conflict), 32'h0);
        chk("b r0 no conflict", 32'(bus_b.rsv_conflict), 32'h0);
        chk("b bypass r3", bus_b.rd_data[31:0], 32'h0034_0078);
        chk("b bypass r3 p3", bus_b.rd_data[127:96], 32'h0034_0078);
        step("b wr r3");
        drive_b(0, 0, 0, 0, 1, 6, 6, 6, 3, 0);
        #1 chk("b r6 pending", 32'(bus_b.rd_ready), 32'hC);
        chk("b r3 stored", bus_b.rd_data[95:64], 32'h0034_0078);
        step("b rsv r6 again");
        drive_b(0, 0, 0, 0, 0, 0, 0, 1, 2, 3);
        #1 chk("b conflict", 32'(bus_b.rsv_conflict), 32'h1);

        // Double reserve on r7 without a write
        drive_a(0, 0, 0, 0, 1, 7, 7, 1); step("rsv r7 a");
        drive_a(0, 0, 0, 0, 1, 7, 7, 1); step("rsv r7 b");
        drive_a(0, 0, 0, 0, 0, 0, 7, 1);
        #1 chk("r7 conflict", 32'(bus_a.rsv_conflict), 32'h1);
        step("r7 idle");
        #1 chk("r7 conflict sticky", 32'(bus_a.rsv_conflict), 32'h1);

        // Randomized traffic, biased to a few registers so hazards are frequent
        for (int n = 0; n < 400; n++) begin
            int wa, ra, r0, r1;
            wa = ($urandom % 4 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            ra = ($urandom % 4 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            r0 = ($urandom % 2 == 0) ? wa : int'($urandom_range(0, 7));
            r1 = int'($urandom_range(0, 31));
            drive_a(bit'($urandom % 2), wa, $urandom, 4'($urandom), bit'($urandom % 3 == 0), ra, r0, r1);
            step($sformatf("rand%0d", n));
        end

        // Asynchronous reset between edges; a write under reset is lost
        drive_a(0, 0, 0, 0, 0, 0, 1, 5);
        #2 rst = 1'b1;
        model_reset();
        #1 check_a("async rst");
        chk("async rst ready_b", 32'(bus_b.rd_ready), 32'hF);
        chk("async rst data_b", bus_b.rd_data[95:64], 32'h0);
        chk("async rst conflict_b", 32'(bus_b.rsv_conflict), 32'h0);
        @(negedge clk);
        drive_a(1, 3, 32'h3333_3333, 4'b1111, 1, 4, 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 3, 4);
        rst = 1'b0;
        step("after rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
